output_queue_bypass_chk: RTL and testbench

//   Per-packet bypass decision for the PIFO output-queue scheduler.

---
 rtl/output_queue_bypass_chk.sv | 52 +++++
 tb/tb_output_queue_bypass_chk.sv | 118 +++++++++++
 2 files changed

// File: rtl/output_queue_bypass_chk.sv
// Per-packet bypass decision for the PIFO output-queue scheduler.
// Registers one decision per input beat: bypass when the calendar is empty or the new rank is lower.
module output_queue_bypass_chk #(
    parameter int unsigned PIFO_INFO_WIDTH = 32,
    parameter int unsigned RANK_WIDTH      = 16,
    parameter int unsigned RANK_LSB        = 0,
    parameter int unsigned TOP_VALID_BIT   = 31
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       s_axis_valid,
    input  logic [PIFO_INFO_WIDTH-1:0] s_axis_pifo_info,
    input  logic [PIFO_INFO_WIDTH-1:0] s_axis_pifo_calandar_top,
    output logic                       m_axis_valid,
    output logic                       m_axis_bypass_en
);

    logic [RANK_WIDTH-1:0] new_rank;
    logic [RANK_WIDTH-1:0] top_rank;
    logic                  top_vld;
    logic                  bypass;
    logic                  valid_d, valid_q;
    logic                  bypass_d, bypass_q;

    // Bits outside the rank field and the valid bit carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axis_pifo_info, s_axis_pifo_calandar_top};

    always_comb begin
        new_rank = s_axis_pifo_info[RANK_LSB +: RANK_WIDTH];
        top_rank = s_axis_pifo_calandar_top[RANK_LSB +: RANK_WIDTH];
        top_vld  = s_axis_pifo_calandar_top[TOP_VALID_BIT];
        // Equal ranks stay behind the queued head to preserve FIFO order.
        bypass   = !top_vld || (new_rank < top_rank);
        valid_d  = s_axis_valid;
        bypass_d = s_axis_valid && bypass;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q  <= 1'b0;
            bypass_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            bypass_q <= bypass_d;
        end
    end

    assign m_axis_valid     = valid_q;
    assign m_axis_bypass_en = bypass_q;

endmodule

// File: tb/tb_output_queue_bypass_chk.sv
// Directed self-checking bench for output_queue_bypass_chk.
module tb_output_queue_bypass_chk;

    logic        clk;
    logic        rstn;
    logic        s_axis_valid;
    logic [31:0] s_axis_pifo_info;
    logic [31:0] s_axis_pifo_calandar_top;
    logic        m_axis_valid;
    logic        m_axis_bypass_en;

    int tests_run;
    int tests_failed;

    output_queue_bypass_chk #(
        .PIFO_INFO_WIDTH(32),
        .RANK_WIDTH     (16),
        .RANK_LSB       (0),
        .TOP_VALID_BIT  (31)
    ) dut (
        .clk                     (clk),
        .rstn                    (rstn),
        .s_axis_valid            (s_axis_valid),
        .s_axis_pifo_info        (s_axis_pifo_info),
        .s_axis_pifo_calandar_top(s_axis_pifo_calandar_top),
        .m_axis_valid            (m_axis_valid),
        .m_axis_bypass_en        (m_axis_bypass_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one beat on the falling edge, then check the registered decision after the rise.
    task automatic beat(input string tag, input logic vld, input logic [31:0] info,
                        input logic [31:0] top, input logic exp_vld, input logic exp_byp);
        @(negedge clk);
        s_axis_valid             = vld;
        s_axis_pifo_info         = info;
        s_axis_pifo_calandar_top = top;
        @(posedge clk);
        #1;
        check({tag, "_valid"}, {31'd0, m_axis_valid}, {31'd0, exp_vld});
        check({tag, "_bypass"}, {31'd0, m_axis_bypass_en}, {31'd0, exp_byp});
    endtask

    initial begin
        tests_run                = 0;
        tests_failed             = 0;
        rstn                     = 1'b0;
        s_axis_valid             = 1'b0;
        s_axis_pifo_info         = 32'd0;
        s_axis_pifo_calandar_top = 32'd0;

        // Reset held with random, valid-qualified inputs.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            s_axis_valid             = 1'b1;
            s_axis_pifo_info         = $urandom;
            s_axis_pifo_calandar_top = $urandom;
            @(posedge clk);
            #1;
            check("rst_valid", {31'd0, m_axis_valid}, 32'd0);
            check("rst_bypass", {31'd0, m_axis_bypass_en}, 32'd0);
        end
        @(negedge clk);
        s_axis_valid = 1'b0;
        rstn         = 1'b1;

        beat("empty_cal", 1'b1, 32'h0000_0050, 32'h0000_0010, 1'b1, 1'b1);

        beat("lt_top", 1'b1, 32'h0000_0010, 32'h8000_0020, 1'b1, 1'b1);
        beat("eq_top", 1'b1, 32'h0000_0020, 32'h8000_0020, 1'b1, 1'b0);
        beat("gt_top", 1'b1, 32'h0000_0030, 32'h8000_0020, 1'b1, 1'b0);

        beat("b2b_0", 1'b1, 32'h0000_0010, 32'h8000_0020, 1'b1, 1'b1);
        beat("b2b_1", 1'b1, 32'h0000_0030, 32'h8000_0020, 1'b1, 1'b0);
        beat("b2b_2", 1'b1, 32'h0000_0005, 32'h8000_0020, 1'b1, 1'b1);
        beat("b2b_3", 1'b1, 32'h0000_0020, 32'h8000_0020, 1'b1, 1'b0);

        beat("zero_zero", 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0);
        beat("zero_max", 1'b1, 32'h0000_0000, 32'h8000_FFFF, 1'b1, 1'b1);
        beat("max_empty", 1'b1, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b1);

        // High bits outside the rank field and valid bit must not matter.
        beat("ign_lt", 1'b1, 32'hABCD_0010, 32'hC0DE_0020, 1'b1, 1'b1);
        beat("ign_gt", 1'b1, 32'h1234_0030, 32'hFFFF_0020, 1'b1, 1'b0);
        beat("ign_vbit", 1'b1, 32'h0000_0010, 32'h7FFF_0005, 1'b1, 1'b1);

        beat("idle_0", 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        beat("idle_1", 1'b0, 32'h0000_0001, 32'h8000_0020, 1'b0, 1'b0);

        // Asynchronous reset while a bypass decision is on the outputs.
        beat("pre_arst", 1'b1, 32'h0000_0001, 32'h8000_0020, 1'b1, 1'b1);
        #1;
        rstn = 1'b0;
        #1;
        check("arst_valid", {31'd0, m_axis_valid}, 32'd0);
        check("arst_bypass", {31'd0, m_axis_bypass_en}, 32'd0);
        @(negedge clk);
        s_axis_valid = 1'b0;
        rstn         = 1'b1;
        beat("post_arst_idle", 1'b0, 32'h0000_0001, 32'h8000_0020, 1'b0, 1'b0);
        beat("post_arst_beat", 1'b1, 32'h0000_0001, 32'h8000_0020, 1'b1, 1'b1);
        beat("tail_idle", 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
